sixteen_bit_div: RTL and testbench
==================================

# sixteen_bit_div

Sequential restoring divider, the inverse of the 16×16 multiplier: it takes a 32-bit product-width dividend and a 16-bit divisor and returns a 16-bit quotient and a 16-bit remainder. It produces one quotient bit per clock under a start/done handshake. Divide-by-zero and quotient overflow are detected up front. It sits beside `sixteen_bit_mul` in the arithmetic tile and reuses the same operand naming.

## Interface
- Parameters: none; widths are fixed at 32-bit dividend and 16-bit divisor, quotient and remainder.
- `clk`  in  1  rising-edge clock
- `rst`  in  1  synchronous, active-high reset
- `start`  in  1  request; sampled only in IDLE or DONE
- `s`  in  32  dividend; latched on accepted start
- `e2`  in  16  divisor; latched on accepted start
- `e1`  out  16  quotient
- `r`  out  16  remainder
- `busy`  out  1  high in RUN
- `done`  out  1  one-cycle completion pulse
- `div_zero`  out  1  last op had `e2`==0
- `ovf`  out  1  last op quotient ≥ 2^16
- `chk_err`  out  1  self-check mismatch; see Configuration

## Operation
- FSM states are IDLE, RUN and DONE. `busy` = (state==RUN). `done` = (state==DONE).
- Accepted start (`start`=1 in IDLE or DONE):
  - Latch `s` and `e2`.
  - Clear `div_zero`, `ovf` and `chk_err`.
- Error checks at accept, in priority order:
  - `e2`==0: go to DONE with `div_zero`=1, `e1`=16'hFFFF, `r`=`s`[15:0].
  - `s`[31:16] ≥ `e2`: go to DONE with `ovf`=1, `e1`=16'hFFFF, `r`=0.
  - Otherwise: go to RUN with the iteration counter at 0.
- Per RUN cycle:
  - Shift the 17-bit partial remainder left, bringing in the next dividend bit (MSB first from `s`[15:0]); upper dividend bits seed the remainder.
  - Trial-subtract the divisor; if the result is non-negative, keep it and shift 1 into the quotient, else shift 0.
  - The counter runs 0..15; on count 15 go to DONE.
- `start` during RUN is ignored. Latched operands are unaffected by input changes during RUN.
- DONE lasts exactly one cycle; next state is RUN/DONE if `start` is accepted, else IDLE.
- `e1`, `r`, `div_zero` and `ovf` hold their values until the next accepted start.
- Invariant on normal completion: `e1`*`e2`+`r`==`s` and `r`<`e2`.

## Timing
- Reset: state IDLE; `e1`, `r`, `busy`, `done`, `div_zero`, `ovf`, `chk_err` all 0.
- Reset mid-RUN aborts the operation; no `done` pulse follows.
- Start sampled at edge k:
  - Normal op: `busy` is high after edges k..k+15; `done` is high for exactly one cycle after edge k+16.
  - Error op: `done` is high after edge k (1-cycle latency); `busy` never rises.
- Back-to-back: `start` held high during DONE is accepted at that edge, so throughput is 1 op / 17 cycles.
- Results are valid when `done` rises. They are registered outputs, and `chk_err` is valid with `done`.

## Configuration
- `SIXTEEN_BIT_DIV_CHECK_EN` defined:
  - Instantiate `sixteen_bit_mul` on (`e1`, latched divisor).
  - In DONE of a normal op, `chk_err` = ((product + `r`) != latched dividend). It is registered, high for the same cycle as `done`, and cleared on the next accepted start.
- `SIXTEEN_BIT_DIV_CHECK_EN` undefined: `chk_err` is tied to 0 and no multiplier is instantiated.

## Structure
- Package `sixteen_bit_div_pkg` holds:
  - the state enum (IDLE, RUN, DONE);
  - constants DIVIDEND_W=32, DIVISOR_W=16, ITER=16, ERR_QUOT=16'hFFFF.
- The datapath and FSM live in one module. The only sub-module is the existing `sixteen_bit_mul`, present under the macro only.

## Test plan
- Reset, then `s`=250, `e2`=25, one-cycle `start` → `busy` for 16 cycles, then `done`, `e1`=10, `r`=0, flags 0.
- `s`=100, `e2`=7 → `e1`=14, `r`=2. `s`=65025, `e2`=255 → `e1`=255, `r`=0. `s`=65535, `e2`=1 → `e1`=65535, `r`=0, `ovf`=0.
- `s`=123, `e2`=0 → `done` 1 cycle after start, `div_zero`=1, `e1`=16'hFFFF, `r`=123.
- `s`=32'h0002_0000, `e2`=2 → `done` after 1 cycle, `ovf`=1, `e1`=16'hFFFF, `r`=0. `s`=32'h0001_FFFF, `e2`=2 → `e1`=16'hFFFF, `r`=1, `ovf`=0.
- During RUN, re-pulse `start` with `s`=7, `e2`=3 and change the inputs → ignored, first result intact. `rst` at iteration 8 → all outputs 0, no `done`.
- `start` held high through DONE → second op accepted at the `done` edge, second `done` 17 cycles after the first. With the macro defined, `chk_err` stays 0 across 1000 random valid ops.

Source files
------------

// File: rtl/sixteen_bit_div_pkg.sv
// Shared types and constants for the sequential 32/16 restoring divider.
package sixteen_bit_div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DIVIDEND_W = 32;
  localparam int DIVISOR_W  = 16;
  localparam int ITER       = 16;
  localparam logic [15:0] ERR_QUOT = 16'hFFFF;

  // One restoring step: returns {quotient bit, next partial remainder}.
  function automatic logic [16:0] div_step(input logic [16:0] rem, input logic [15:0] d);
    if (rem >= {1'b0, d}) begin
      return {1'b1, 16'(rem - {1'b0, d})};
    end
    return {1'b0, rem[15:0]};
  endfunction

endpackage

// File: rtl/sixteen_bit_mul.sv
// 16x16 unsigned multiplier from the arithmetic tile; used by the divider's optional self-check.
module sixteen_bit_mul (
  input  logic [15:0] e1,
  input  logic [15:0] e2,
  output logic [31:0] s
);

  assign s = e1 * e2;

endmodule

// File: rtl/sixteen_bit_div.sv
// Sequential restoring divider, 32-bit dividend by 16-bit divisor, one quotient bit per clock.
// Optional result self-check against sixteen_bit_mul under SIXTEEN_BIT_DIV_CHECK_EN.
module sixteen_bit_div
  import sixteen_bit_div_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] s,
  input  logic [15:0] e2,
  output logic [15:0] e1,
  output logic [15:0] r,
  output logic        busy,
  output logic        done,
  output logic        div_zero,
  output logic        ovf,
  output logic        chk_err
);

  state_t      state;
  logic [3:0]  cnt;
  logic [15:0] dvd_lo;
  logic [15:0] div_q;
  logic [15:0] rem_q;
  logic [15:0] quo_q;

  logic [16:0] step;
  logic [15:0] quo_nxt;
  logic        last;
  logic        accept;

  // Partial remainder never exceeds the divisor, so 16 stored bits plus the incoming bit suffice.
  assign step    = div_step({rem_q, dvd_lo[15]}, div_q);
  assign quo_nxt = {quo_q[14:0], step[16]};
  assign last    = (state == RUN) && (cnt == 4'(ITER - 1));
  assign accept  = start && ((state == IDLE) || (state == DONE));

  assign busy = (state == RUN);
  assign done = (state == DONE);

`ifdef SIXTEEN_BIT_DIV_CHECK_EN
  logic [31:0] dvd_q;
  logic [31:0] prod;
  logic        chk_q;

  // Checks the quotient being committed this cycle so the flag lands together with done.
  sixteen_bit_mul u_mul (
    .e1 (quo_nxt),
    .e2 (div_q),
    .s  (prod)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      chk_q <= 1'b0;
    end else if (last) begin
      chk_q <= ((prod + {16'd0, step[15:0]}) != dvd_q);
    end else begin
      chk_q <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      dvd_q <= s;
    end
  end

  assign chk_err = chk_q;
`else
  assign chk_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      e1       <= '0;
      r        <= '0;
      div_zero <= 1'b0;
      ovf      <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (accept) begin
            div_zero <= 1'b0;
            ovf      <= 1'b0;
            dvd_lo   <= s[15:0];
            rem_q    <= s[31:16];
            div_q    <= e2;
            quo_q    <= '0;
            cnt      <= '0;
            if (e2 == 16'd0) begin
              div_zero <= 1'b1;
              e1       <= ERR_QUOT;
              r        <= s[15:0];
              state    <= DONE;
            end else if (s[31:16] >= e2) begin
              ovf      <= 1'b1;
              e1       <= ERR_QUOT;
              r        <= '0;
              state    <= DONE;
            end else begin
              state    <= RUN;
            end
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          rem_q  <= step[15:0];
          quo_q  <= quo_nxt;
          dvd_lo <= {dvd_lo[14:0], 1'b0};
          cnt    <= cnt + 4'd1;
          if (last) begin
            e1    <= quo_nxt;
            r     <= step[15:0];
            state <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sixteen_bit_div.sv
// Directed self-checking bench for sixteen_bit_div (handshake, error paths, abort, back-to-back).
module tb_sixteen_bit_div;

  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] s;
  logic [15:0] e2;
  logic [15:0] e1;
  logic [15:0] r;
  logic        busy;
  logic        done;
  logic        div_zero;
  logic        ovf;
  logic        chk_err;

  int n_chk;
  int n_fail;

  sixteen_bit_div dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .s        (s),
    .e2       (e2),
    .e1       (e1),
    .r        (r),
    .busy     (busy),
    .done     (done),
    .div_zero (div_zero),
    .ovf      (ovf),
    .chk_err  (chk_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive a one-cycle start; returns #1 after the accepting edge.
  task automatic start_op(input logic [31:0] sv, input logic [15:0] dv);
    @(negedge clk);
    s = sv; e2 = dv; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Edges until done is seen (0 = already high), busy cycles seen on the way; bounded.
  task automatic wait_done(output int lat, output int nbusy);
    lat = 0; nbusy = 0;
    while (!done && lat < 40) begin
      if (busy) nbusy++;
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; s = '0; e2 = '0;
    repeat (3) @(posedge clk);
    #1;
    n_chk++;
    if ({e1, r, busy, done, div_zero, ovf, chk_err} !== 37'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got e1=%0d r=%0d busy=%b done=%b dz=%b ovf=%b chk=%b, expected all 0",
               e1, r, busy, done, div_zero, ovf, chk_err);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    n_chk++;
    if ({busy, done} !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_idle: got busy=%b done=%b, expected 0 0", busy, done);
    end
  endtask

  task automatic test_normal();
    logic [31:0] sv [4] = '{32'd250, 32'd100, 32'd65025, 32'd65535};
    logic [15:0] dv [4] = '{16'd25, 16'd7, 16'd255, 16'd1};
    logic [15:0] qx [4] = '{16'd10, 16'd14, 16'd255, 16'd65535};
    logic [15:0] rx [4] = '{16'd0, 16'd2, 16'd0, 16'd0};
    int lat, nb;
    for (int i = 0; i < 4; i++) begin
      start_op(sv[i], dv[i]);
      wait_done(lat, nb);
      n_chk++;
      if (lat !== 16 || nb !== 16) begin
        n_fail++;
        $display("FAIL normal_timing[%0d]: got latency=%0d busy_cycles=%0d, expected 16 16", i, lat, nb);
      end
      n_chk++;
      if (e1 !== qx[i] || r !== rx[i]) begin
        n_fail++;
        $display("FAIL normal_result[%0d]: got q=%0d r=%0d, expected q=%0d r=%0d", i, e1, r, qx[i], rx[i]);
      end
      n_chk++;
      if ({div_zero, ovf, chk_err} !== 3'b000) begin
        n_fail++;
        $display("FAIL normal_flags[%0d]: got dz=%b ovf=%b chk=%b, expected 0", i, div_zero, ovf, chk_err);
      end
      @(posedge clk); #1;
      n_chk++;
      if (done !== 1'b0 || e1 !== qx[i] || r !== rx[i]) begin
        n_fail++;
        $display("FAIL normal_hold[%0d]: got done=%b q=%0d r=%0d, expected done=0 q=%0d r=%0d",
                 i, done, e1, r, qx[i], rx[i]);
      end
    end
  endtask

  task automatic test_div_zero();
    int lat, nb;
    start_op(32'd123, 16'd0);
    wait_done(lat, nb);
    n_chk++;
    if (lat !== 0 || nb !== 0) begin
      n_fail++;
      $display("FAIL dz_timing: got latency=%0d busy_cycles=%0d, expected 0 0", lat, nb);
    end
    n_chk++;
    if (div_zero !== 1'b1 || ovf !== 1'b0 || e1 !== 16'hFFFF || r !== 16'd123) begin
      n_fail++;
      $display("FAIL dz_result: got dz=%b ovf=%b q=%h r=%0d, expected dz=1 ovf=0 q=ffff r=123",
               div_zero, ovf, e1, r);
    end
    @(posedge clk); #1;
    n_chk++;
    if (done !== 1'b0 || div_zero !== 1'b1) begin
      n_fail++;
      $display("FAIL dz_hold: got done=%b dz=%b, expected done=0 dz=1", done, div_zero);
    end
  endtask

  task automatic test_ovf();
    int lat, nb;
    start_op(32'h0002_0000, 16'd2);
    wait_done(lat, nb);
    n_chk++;
    if (lat !== 0 || nb !== 0) begin
      n_fail++;
      $display("FAIL ovf_timing: got latency=%0d busy_cycles=%0d, expected 0 0", lat, nb);
    end
    n_chk++;
    if (ovf !== 1'b1 || div_zero !== 1'b0 || e1 !== 16'hFFFF || r !== 16'd0) begin
      n_fail++;
      $display("FAIL ovf_result: got ovf=%b dz=%b q=%h r=%0d, expected ovf=1 dz=0 q=ffff r=0",
               ovf, div_zero, e1, r);
    end
    start_op(32'h0001_FFFF, 16'd2);
    wait_done(lat, nb);
    n_chk++;
    if (lat !== 16 || ovf !== 1'b0 || e1 !== 16'hFFFF || r !== 16'd1) begin
      n_fail++;
      $display("FAIL ovf_edge: got latency=%0d ovf=%b q=%h r=%0d, expected 16 0 ffff 1", lat, ovf, e1, r);
    end
  endtask

  task automatic test_start_during_run();
    int lat, nb;
    start_op(32'd250, 16'd25);
    repeat (4) @(posedge clk);
    @(negedge clk);
    s = 32'd7; e2 = 16'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; s = 32'hDEAD_BEEF; e2 = 16'h1234;
    n_chk++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL ignore_busy: got busy=%b, expected 1", busy);
    end
    wait_done(lat, nb);
    n_chk++;
    if (lat !== 11 || e1 !== 16'd10 || r !== 16'd0) begin
      n_fail++;
      $display("FAIL ignore_result: got latency=%0d q=%0d r=%0d, expected 11 10 0", lat, e1, r);
    end
  endtask

  task automatic test_reset_mid_run();
    int ndone;
    start_op(32'd100, 16'd7);
    repeat (8) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_chk++;
    if ({e1, r, busy, done, div_zero, ovf, chk_err} !== 37'd0) begin
      n_fail++;
      $display("FAIL abort_outputs: got e1=%0d r=%0d busy=%b done=%b dz=%b ovf=%b chk=%b, expected all 0",
               e1, r, busy, done, div_zero, ovf, chk_err);
    end
    ndone = 0;
    repeat (30) begin
      @(posedge clk); #1;
      if (done) ndone++;
    end
    n_chk++;
    if (ndone !== 0) begin
      n_fail++;
      $display("FAIL abort_no_done: got %0d done cycles, expected 0", ndone);
    end
  endtask

  task automatic test_back_to_back();
    int lat, nb;
    @(negedge clk);
    s = 32'd100; e2 = 16'd7; start = 1'b1;
    @(posedge clk); #1;
    s = 32'd250; e2 = 16'd25;
    wait_done(lat, nb);
    n_chk++;
    if (lat !== 16 || e1 !== 16'd14 || r !== 16'd2) begin
      n_fail++;
      $display("FAIL b2b_first: got latency=%0d q=%0d r=%0d, expected 16 14 2", lat, e1, r);
    end
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
      if (lat == 1) start = 1'b0;
    end while (!done && lat < 40);
    n_chk++;
    if (lat !== 17 || e1 !== 16'd10 || r !== 16'd0) begin
      n_fail++;
      $display("FAIL b2b_second: got spacing=%0d q=%0d r=%0d, expected 17 10 0", lat, e1, r);
    end
    @(posedge clk); #1;
    n_chk++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_idle: got done=%b busy=%b, expected 0 0", done, busy);
    end
  endtask

  task automatic test_random();
    int lat, nb;
    logic [31:0] q, d, rr, sv;
    for (int i = 0; i < 1000; i++) begin
      q  = $urandom_range(0, 65535);
      d  = $urandom_range(1, 65535);
      rr = $urandom_range(0, d - 1);
      sv = q * d + rr;
      start_op(sv, d[15:0]);
      wait_done(lat, nb);
      n_chk++;
      if (lat !== 16 || e1 !== q[15:0] || r !== rr[15:0] || chk_err !== 1'b0 || ovf !== 1'b0) begin
        n_fail++;
        $display("FAIL random[%0d]: s=%h d=%0d got lat=%0d q=%0d r=%0d chk=%b ovf=%b, expected 16 %0d %0d 0 0",
                 i, sv, d, lat, e1, r, chk_err, ovf, q, rr);
      end
    end
  endtask

  initial begin
    n_chk = 0;
    n_fail = 0;
    test_reset();
    test_normal();
    test_div_zero();
    test_ovf();
    test_start_during_run();
    test_reset_mid_run();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
